reg_file_mp: RTL and testbench

Parametrised multi-port register file for the next-generation MIPS datapath (dual-issue capable).
- Generalises the single-write/dual-read file to NUM_RD combinational read ports and NUM_WR write ports.
- Adds an optional hardwired zero register and a per-register busy scoreboard that tracks pending writebacks.
- Sits between decode/issue (reads, busy marking) and writeback (writes, busy clearing).

---
 rtl/reg_file_mp_pkg.sv | 24 ++
 rtl/reg_file_mp_if.sv | 44 ++++
 rtl/reg_file_mp_scoreboard.sv | 75 +++++++
 rtl/reg_file_mp.sv | 163 ++++++++++++++++
 tb/tb_reg_file_mp.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_mp_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg -- shared constants and helpers for the multi-port register file.
//
// Contents:
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default register width and address width
//   DEF_NUM_RD / DEF_NUM_WR         : default port counts
//   MAX_RD / MAX_WR                 : supported upper limits on the port counts
//   slice_lo()                      : low bit of port k in a flat packed bus
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NUM_RD     = 2;
    localparam int DEF_NUM_WR     = 2;
    localparam int MAX_RD         = 4;
    localparam int MAX_WR         = 2;

    // Port k of a flat bus of w-bit fields occupies [(k+1)*w-1 : k*w].
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// ---------------------------------------------------------------------------
// reg_file_mp_if -- bus bundle between issue/writeback logic and the
// multi-port register file.
//
// Signals (flat packing, port k in slice k):
//   Rd_Addr     : read addresses           (master -> slave)
//   Rd_Data     : read data                (slave  -> master)
//   Rd_Busy     : busy flag per read port  (slave  -> master)
//   Wr_En       : write enable per port    (master -> slave)
//   Wr_Addr     : write addresses          (master -> slave)
//   Wr_Data     : write data               (master -> slave)
//   Iss_En      : mark Iss_Addr busy       (master -> slave)
//   Iss_Addr    : register to mark busy    (master -> slave)
//   Wr_Conflict : registered conflict pulse(slave  -> master)
// Modports: master (datapath side), slave (register file side).
// ---------------------------------------------------------------------------
interface reg_file_mp_if
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int NUM_WR     = DEF_NUM_WR
);
    logic [NUM_RD*ADDR_WIDTH-1:0] Rd_Addr;
    logic [NUM_RD*DATA_WIDTH-1:0] Rd_Data;
    logic [NUM_RD-1:0]            Rd_Busy;
    logic [NUM_WR-1:0]            Wr_En;
    logic [NUM_WR*ADDR_WIDTH-1:0] Wr_Addr;
    logic [NUM_WR*DATA_WIDTH-1:0] Wr_Data;
    logic                         Iss_En;
    logic [ADDR_WIDTH-1:0]        Iss_Addr;
    logic                         Wr_Conflict;

    modport master (
        output Rd_Addr, Wr_En, Wr_Addr, Wr_Data, Iss_En, Iss_Addr,
        input  Rd_Data, Rd_Busy, Wr_Conflict
    );

    modport slave (
        input  Rd_Addr, Wr_En, Wr_Addr, Wr_Data, Iss_En, Iss_Addr,
        output Rd_Data, Rd_Busy, Wr_Conflict
    );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard -- one busy bit per register, tracking issued producers
// whose writeback has not happened yet.
//
// Ports:
//   CLK, RST  : clock, synchronous active-high reset (clears all busy bits)
//   iss_en    : mark iss_addr busy on this edge
//   iss_addr  : register being marked busy
//   wr_en     : write enable per write port (a write clears busy)
//   wr_addr   : flat write addresses
//   rd_addr   : flat read addresses
//   rd_busy   : stored busy bit of each read port's register (no bypass)
//
// A set and a clear on the same register in one cycle leaves it busy: the
// issue belongs to a newer producer than the one writing back now.
// ---------------------------------------------------------------------------
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int NUM_WR     = DEF_NUM_WR,
    parameter int ZERO_REG   = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         iss_en,
    input  logic [ADDR_WIDTH-1:0]        iss_addr,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD-1:0]            rd_busy
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] set_hit;
    logic [DEPTH-1:0] clr_hit;

    genvar gi;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_busy
            always_comb begin
                set_hit[gi] = iss_en && (iss_addr == ADDR_WIDTH'(gi));
                clr_hit[gi] = 1'b0;
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && (wr_addr[slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH] == ADDR_WIDTH'(gi)))
                        clr_hit[gi] = 1'b1;
                end
            end

            if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
                // Hardwired zero register never has a pending producer.
                always_ff @(posedge CLK) begin
                    busy_reg[gi] <= 1'b0;
                end
            end else begin : g_norm
                always_ff @(posedge CLK) begin
                    if (RST)
                        busy_reg[gi] <= 1'b0;
                    else if (set_hit[gi])
                        busy_reg[gi] <= 1'b1;
                    else if (clr_hit[gi])
                        busy_reg[gi] <= 1'b0;
                end
            end
        end

        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            assign rd_busy[gi] = busy_reg[rd_addr[slice_lo(gi, ADDR_WIDTH) +: ADDR_WIDTH]];
        end
    endgenerate

endmodule

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp -- parametrised multi-port register file with busy scoreboard.
//
// Ports:
//   CLK : clock, all state changes on the rising edge
//   RST : synchronous active-high reset (registers, busy bits, Wr_Conflict)
//   rf  : reg_file_mp_if.slave bundle (read ports, write ports, issue port,
//         Wr_Conflict pulse)
//
// Reads are combinational. Simultaneous writes to the same register resolve
// to the highest port index, and Wr_Conflict pulses for one cycle afterwards.
// With ZERO_REG=1 register 0 reads 0, drops writes and is never busy.
//
// Optional: define RF_BYPASS_EN to forward same-cycle write data to reads
// (highest matching write port wins, forwarded reads report not-busy).
// ---------------------------------------------------------------------------
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int NUM_WR     = DEF_NUM_WR,
    parameter int ZERO_REG   = 1
) (
    input  logic         CLK,
    input  logic         RST,
    reg_file_mp_if.slave rf
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

    logic [ADDR_WIDTH-1:0] rd_addr  [NUM_RD];
    logic [ADDR_WIDTH-1:0] wr_addr  [NUM_WR];
    logic [DATA_WIDTH-1:0] wr_data  [NUM_WR];
    logic [NUM_WR-1:0]     wr_en;
    logic [NUM_WR-1:0]     wr_keep;

    logic [DEPTH-1:0]      reg_hit;
    logic [DATA_WIDTH-1:0] reg_wdata [DEPTH];

    logic                  conflict_reg;
    logic                  conflict_next;

    logic [DATA_WIDTH-1:0] rd_data_next [NUM_RD];
    logic [NUM_RD-1:0]     rd_fwd;
    logic [NUM_RD-1:0]     sb_busy;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_flat;

    genvar gi;

    // ---------------- unpack the flat buses ----------------
    assign wr_en = rf.Wr_En;

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd_unpack
            assign rd_addr[gi] = rf.Rd_Addr[slice_lo(gi, ADDR_WIDTH) +: ADDR_WIDTH];
        end

        for (gi = 0; gi < NUM_WR; gi++) begin : g_wr_unpack
            assign wr_addr[gi] = rf.Wr_Addr[slice_lo(gi, ADDR_WIDTH) +: ADDR_WIDTH];
            assign wr_data[gi] = rf.Wr_Data[slice_lo(gi, DATA_WIDTH) +: DATA_WIDTH];
            // Writes aimed at the hardwired zero register are discarded here,
            // so neither storage nor conflict detection ever sees them.
            assign wr_keep[gi] = wr_en[gi] &&
                                 !((ZERO_REG != 0) && (wr_addr[gi] == '0));
        end
    endgenerate

    // ---------------- storage ----------------
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            // Later ports overwrite earlier ones, so the highest index wins.
            always_comb begin
                reg_hit[gi]   = 1'b0;
                reg_wdata[gi] = '0;
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_keep[j] && (wr_addr[j] == ADDR_WIDTH'(gi))) begin
                        reg_hit[gi]   = 1'b1;
                        reg_wdata[gi] = wr_data[j];
                    end
                end
            end

            always_ff @(posedge CLK) begin
                if (RST)
                    mem_reg[gi] <= '0;
                else if (reg_hit[gi])
                    mem_reg[gi] <= reg_wdata[gi];
            end
        end
    endgenerate

    // ---------------- write conflict detection ----------------
    always_comb begin
        conflict_next = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wr_keep[i] && wr_keep[j] && (wr_addr[i] == wr_addr[j]))
                    conflict_next = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            conflict_reg <= 1'b0;
        else
            conflict_reg <= conflict_next;
    end

    assign rf.Wr_Conflict = conflict_reg;

    // ---------------- scoreboard ----------------
    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_RD     (NUM_RD),
        .NUM_WR     (NUM_WR),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .CLK      (CLK),
        .RST      (RST),
        .iss_en   (rf.Iss_En),
        .iss_addr (rf.Iss_Addr),
        .wr_en    (rf.Wr_En),
        .wr_addr  (rf.Wr_Addr),
        .rd_addr  (rf.Rd_Addr),
        .rd_busy  (sb_busy)
    );

    // ---------------- read ports ----------------
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_read
            always_comb begin
                rd_data_next[gi] = mem_reg[rd_addr[gi]];
                rd_fwd[gi]       = 1'b0;
`ifdef RF_BYPASS_EN
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && (wr_addr[j] == rd_addr[gi])) begin
                        rd_data_next[gi] = wr_data[j];
                        rd_fwd[gi]       = 1'b1;
                    end
                end
`endif
                // Zero register overrides any forwarded value.
                if ((ZERO_REG != 0) && (rd_addr[gi] == '0))
                    rd_data_next[gi] = '0;
            end

            assign rf.Rd_Busy[gi] = sb_busy[gi] & ~rd_fwd[gi];
        end
    endgenerate

    always_comb begin
        rd_data_flat = '0;
        for (int k = 0; k < NUM_RD; k++)
            rd_data_flat[k*DATA_WIDTH +: DATA_WIDTH] = rd_data_next[k];
    end

    assign rf.Rd_Data = rd_data_flat;

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp -- self-checking bench for reg_file_mp (default parameters,
// ZERO_REG=1). A behavioural register/busy model is updated on each rising
// edge; outputs are compared against it on every falling edge, plus directed
// literal checks. Define RF_BYPASS_EN for both bench and RTL to cover
// forwarding.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int ZR = 1;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst;

    reg_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

    reg_file_mp #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_RD     (NR),
        .NUM_WR     (NW),
        .ZERO_REG   (ZR)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .rf  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    logic [DW-1:0] m_mem  [DEPTH];
    logic          m_busy [DEPTH];
    logic          m_conf;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] wa(input int j);
        return bus.Wr_Addr[j*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] wd(input int j);
        return bus.Wr_Data[j*DW +: DW];
    endfunction

    function automatic logic [AW-1:0] ra(input int k);
        return bus.Rd_Addr[k*AW +: AW];
    endfunction

    // Expected read result for port k under the current inputs.
    task automatic exp_read(input int k, output logic [DW-1:0] d, output logic b);
        logic [AW-1:0] a;
        a = ra(k);
        d = m_mem[a];
        b = m_busy[a];
`ifdef RF_BYPASS_EN
        for (int j = 0; j < NW; j++) begin
            if (bus.Wr_En[j] && wa(j) == a) begin
                d = wd(j);
                b = 1'b0;
            end
        end
`endif
        if (ZR != 0 && a == '0) begin
            d = '0;
            b = 1'b0;
        end
    endtask

    // Architectural state update at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                m_mem[r]  = '0;
                m_busy[r] = 1'b0;
            end
            m_conf = 1'b0;
        end else begin
            m_conf = (bus.Wr_En == 2'b11) && (wa(0) == wa(1)) && !(ZR != 0 && wa(0) == '0);
            for (int j = 0; j < NW; j++) begin
                if (bus.Wr_En[j]) begin
                    if (!(ZR != 0 && wa(j) == '0))
                        m_mem[wa(j)] = wd(j);
                    m_busy[wa(j)] = 1'b0;
                end
            end
            if (bus.Iss_En)
                m_busy[bus.Iss_Addr] = 1'b1;
            if (ZR != 0)
                m_busy[0] = 1'b0;
        end
    end

    // Compare process: every cycle once out of reset.
    always @(negedge clk) begin
        if (check_en) begin
            logic [DW-1:0] ed;
            logic          eb;
            for (int k = 0; k < NR; k++) begin
                exp_read(k, ed, eb);
                chk($sformatf("model rd_data[%0d] addr %0d", k, ra(k)), bus.Rd_Data[k*DW +: DW], ed);
                chk($sformatf("model rd_busy[%0d] addr %0d", k, ra(k)), DW'(bus.Rd_Busy[k]), DW'(eb));
            end
            chk("model wr_conflict", DW'(bus.Wr_Conflict), DW'(m_conf));
        end
    end

    task automatic idle();
        bus.Wr_En    = '0;
        bus.Wr_Addr  = '0;
        bus.Wr_Data  = '0;
        bus.Iss_En   = 1'b0;
        bus.Iss_Addr = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 1) == 0)
            return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        // Reset with writes and an issue pending: all must be ignored.
        rst          = 1'b1;
        bus.Wr_En    = 2'b11;
        bus.Wr_Addr  = {5'd3, 5'd5};
        bus.Wr_Data  = {32'hDEADBEEF, 32'hDEADBEEF};
        bus.Iss_En   = 1'b1;
        bus.Iss_Addr = 5'd3;
        bus.Rd_Addr  = {5'd3, 5'd5};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        check_en = 1'b1;
        @(negedge clk);
        chk("reset rd_data0", bus.Rd_Data[31:0], 32'h0);
        chk("reset rd_data1", bus.Rd_Data[63:32], 32'h0);
        chk("reset rd_busy", DW'(bus.Rd_Busy), 32'h0);
        chk("reset wr_conflict", DW'(bus.Wr_Conflict), 32'h0);

        // Dual write then read back.
        next_cycle();
        bus.Wr_En = 2'b11; bus.Wr_Addr = {5'd9, 5'd5};
        bus.Wr_Data = {32'h22222222, 32'h11111111};
        bus.Rd_Addr = {5'd1, 5'd2};
        next_cycle();
        idle(); bus.Rd_Addr = {5'd9, 5'd5};
        @(negedge clk);
        chk("dual rd r5", bus.Rd_Data[31:0], 32'h11111111);
        chk("dual rd r9", bus.Rd_Data[63:32], 32'h22222222);

        // Conflict: both ports to r7, port 1 wins.
        next_cycle();
        bus.Wr_En = 2'b11; bus.Wr_Addr = {5'd7, 5'd7};
        bus.Wr_Data = {32'h0000BBBB, 32'hAAAA0000};
        bus.Rd_Addr = {5'd1, 5'd2};
        next_cycle();
        idle(); bus.Rd_Addr = {5'd7, 5'd7};
        @(negedge clk);
        chk("conflict r7 value", bus.Rd_Data[31:0], 32'h0000BBBB);
        chk("conflict pulse", DW'(bus.Wr_Conflict), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("conflict pulse end", DW'(bus.Wr_Conflict), 32'h0);

        // Zero register: write and issue on r0.
        next_cycle();
        bus.Wr_En = 2'b01; bus.Wr_Addr = {5'd0, 5'd0};
        bus.Wr_Data = {32'h0, 32'hFFFFFFFF};
        bus.Iss_En = 1'b1; bus.Iss_Addr = 5'd0;
        next_cycle();
        idle(); bus.Rd_Addr = {5'd0, 5'd0};
        @(negedge clk);
        chk("zero rd_data", bus.Rd_Data[31:0], 32'h0);
        chk("zero rd_busy", DW'(bus.Rd_Busy), 32'h0);

        // Conflict on r0 must not flag.
        next_cycle();
        bus.Wr_En = 2'b11; bus.Wr_Addr = {5'd0, 5'd0};
        bus.Wr_Data = {32'h5, 32'h6};
        next_cycle();
        idle();
        @(negedge clk);
        chk("zero conflict no flag", DW'(bus.Wr_Conflict), 32'h0);

        // Scoreboard: issue r3, then write r3, then issue+write together.
        next_cycle();
        bus.Iss_En = 1'b1; bus.Iss_Addr = 5'd3; bus.Rd_Addr = {5'd1, 5'd2};
        next_cycle();
        idle(); bus.Rd_Addr = {5'd3, 5'd3};
        @(negedge clk);
        chk("sb busy after issue", DW'(bus.Rd_Busy), 32'h3);
        next_cycle();
        bus.Wr_En = 2'b01; bus.Wr_Addr = {5'd0, 5'd3}; bus.Wr_Data = {32'h0, 32'h33};
        next_cycle();
        idle();
        @(negedge clk);
        chk("sb busy cleared", DW'(bus.Rd_Busy), 32'h0);
        next_cycle();
        bus.Wr_En = 2'b10; bus.Wr_Addr = {5'd3, 5'd0}; bus.Wr_Data = {32'h44, 32'h0};
        bus.Iss_En = 1'b1; bus.Iss_Addr = 5'd3;
        next_cycle();
        idle();
        @(negedge clk);
        chk("sb set wins", DW'(bus.Rd_Busy), 32'h3);
        chk("sb write landed", bus.Rd_Data[31:0], 32'h44);

        // Bypass: r4 holds an old value, then write and read in one cycle.
        next_cycle();
        bus.Wr_En = 2'b01; bus.Wr_Addr = {5'd0, 5'd4}; bus.Wr_Data = {32'h0, 32'hCAFE0004};
        bus.Rd_Addr = {5'd1, 5'd2};
        next_cycle();
        bus.Wr_En = 2'b01; bus.Wr_Addr = {5'd0, 5'd4}; bus.Wr_Data = {32'h0, 32'h12345678};
        bus.Rd_Addr = {5'd4, 5'd4};
        @(negedge clk);
`ifdef RF_BYPASS_EN
        chk("bypass same cycle", bus.Rd_Data[31:0], 32'h12345678);
`else
        chk("no bypass old value", bus.Rd_Data[31:0], 32'hCAFE0004);
`endif
        next_cycle();
        idle();
        @(negedge clk);
        chk("bypass next cycle", bus.Rd_Data[63:32], 32'h12345678);

        // Randomised traffic checked by the compare process.
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            bus.Wr_En    = NW'($urandom_range(0, 3));
            bus.Wr_Addr  = {rand_addr(), rand_addr()};
            bus.Wr_Data  = {32'($urandom), 32'($urandom)};
            bus.Iss_En   = ($urandom_range(0, 2) == 0);
            bus.Iss_Addr = rand_addr();
            bus.Rd_Addr  = {rand_addr(), rand_addr()};
            if ($urandom_range(0, 3) == 0)
                bus.Wr_Addr = {bus.Wr_Addr[4:0], bus.Wr_Addr[4:0]};
            if ($urandom_range(0, 3) == 0)
                bus.Rd_Addr = {bus.Wr_Addr[9:5], bus.Iss_Addr};
        end

        next_cycle();
        idle();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
